// File: rtl/cpu_bus_pkg.sv
// Shared constants for the CPU datapath bus: widths and the index of every bus source.
package cpu_bus_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int NUM_SRC       = 24;
  localparam int SEL_WIDTH     = 5;
  localparam int ERR_CNT_WIDTH = 8;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

endpackage

// File: rtl/bus_encoder.sv
// Priority encoder for the bus drive strobes: lowest set bit wins, plus any/multi flags.
module bus_encoder #(
  parameter int NUM_SRC   = cpu_bus_pkg::NUM_SRC,
  parameter int SEL_WIDTH = cpu_bus_pkg::SEL_WIDTH
) (
  input  logic [NUM_SRC-1:0]   strobes,
  output logic [SEL_WIDTH-1:0] index,
  output logic                 any_set,
  output logic                 multi_set
);

  always_comb begin
    index = '0;
    // Scan downward so the last assignment made is the lowest set bit.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (strobes[i]) index = SEL_WIDTH'(i);
    end
    any_set   = |strobes;
    multi_set = |(strobes & (strobes - NUM_SRC'(1)));
  end

endmodule

// File: rtl/bus_mux_driver.sv
// Registered datapath bus driver: selects the strobed source, keeps the last value when
// nothing drives, and flags/counts multi-driver contention.
module bus_mux_driver #(
  parameter int DATA_WIDTH    = cpu_bus_pkg::DATA_WIDTH,
  parameter int NUM_SRC       = cpu_bus_pkg::NUM_SRC,
  parameter int SEL_WIDTH     = cpu_bus_pkg::SEL_WIDTH,
  parameter int ERR_CNT_WIDTH = cpu_bus_pkg::ERR_CNT_WIDTH
) (
  input  logic                          clock,
  input  logic                          clear_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_out,
  input  logic                          err_clr,
  output logic [DATA_WIDTH-1:0]         BusMuxOut,
  output logic [SEL_WIDTH-1:0]          bus_sel,
  output logic                          bus_valid,
  output logic                          contention,
  output logic                          contention_sticky,
  output logic [ERR_CNT_WIDTH-1:0]      contention_cnt
);

  logic [SEL_WIDTH-1:0]  enc_index;
  logic                  enc_any;
  logic                  enc_multi;
  logic [DATA_WIDTH-1:0] words [NUM_SRC];

  bus_encoder #(
    .NUM_SRC   (NUM_SRC),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_encoder (
    .strobes   (src_out),
    .index     (enc_index),
    .any_set   (enc_any),
    .multi_set (enc_multi)
  );

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      words[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // bus_valid marks a cycle whose BusMuxOut came from a source; low means keeper hold.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      BusMuxOut         <= '0;
      bus_sel           <= '0;
      bus_valid         <= 1'b0;
      contention        <= 1'b0;
      contention_sticky <= 1'b0;
      contention_cnt    <= '0;
    end else begin
      if (enc_any) begin
        BusMuxOut <= words[enc_index];
        bus_sel   <= enc_index;
      end
      bus_valid  <= enc_any;
      contention <= enc_multi;
      // A new contention event takes precedence over a same-cycle clear.
      if (enc_multi) begin
        contention_sticky <= 1'b1;
        if (err_clr) begin
          contention_cnt <= ERR_CNT_WIDTH'(1);
        end else if (contention_cnt != '1) begin
          contention_cnt <= contention_cnt + ERR_CNT_WIDTH'(1);
        end
      end else if (err_clr) begin
        contention_sticky <= 1'b0;
        contention_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_mux_driver.sv
// Directed bench for bus_mux_driver: vector table plus hand-written multi-cycle sequences.
module tb_bus_mux_driver;
  import cpu_bus_pkg::*;

  logic                          clock;
  logic                          clear_n;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_out;
  logic                          err_clr;
  logic [DATA_WIDTH-1:0]         bus_mux_out;
  logic [SEL_WIDTH-1:0]          bus_sel;
  logic                          bus_valid;
  logic                          contention;
  logic                          contention_sticky;
  logic [ERR_CNT_WIDTH-1:0]      contention_cnt;

  int checks = 0;
  int errors = 0;

  bus_mux_driver dut (
    .clock             (clock),
    .clear_n           (clear_n),
    .src_data          (src_data),
    .src_out           (src_out),
    .err_clr           (err_clr),
    .BusMuxOut         (bus_mux_out),
    .bus_sel           (bus_sel),
    .bus_valid         (bus_valid),
    .contention        (contention),
    .contention_sticky (contention_sticky),
    .contention_cnt    (contention_cnt)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [NUM_SRC-1:0]       strobes;
    logic                     clr;
    logic [DATA_WIDTH-1:0]    bus;
    logic [SEL_WIDTH-1:0]     sel;
    logic                     valid;
    logic                     cont;
    logic                     sticky;
    logic [ERR_CNT_WIDTH-1:0] cnt;
  } vec_t;

  vec_t vecs[30];

  // Driver tasks
  task automatic set_word(input int idx, input logic [DATA_WIDTH-1:0] val);
    src_data[idx*DATA_WIDTH +: DATA_WIDTH] = val;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [DATA_WIDTH-1:0] bus,
                           input logic [SEL_WIDTH-1:0] sel, input logic valid,
                           input logic cont, input logic sticky,
                           input logic [ERR_CNT_WIDTH-1:0] cnt);
    check({tag, ".bus"}, bus_mux_out, bus);
    check({tag, ".sel"}, 32'(bus_sel), 32'(sel));
    check({tag, ".valid"}, 32'(bus_valid), 32'(valid));
    check({tag, ".cont"}, 32'(contention), 32'(cont));
    check({tag, ".sticky"}, 32'(contention_sticky), 32'(sticky));
    check({tag, ".cnt"}, 32'(contention_cnt), 32'(cnt));
  endtask

  initial begin
    vec_t v;
    logic [DATA_WIDTH-1:0] pattern;

    // Sweep: source i alone, word i*0x01010101, no contention.
    for (int i = 0; i < NUM_SRC; i++) begin
      v.strobes = '0;
      v.strobes[i] = 1'b1;
      v.clr = 1'b0;
      v.bus = DATA_WIDTH'(i) * 32'h0101_0101;
      v.sel = SEL_WIDTH'(i);
      v.valid = 1'b1; v.cont = 1'b0; v.sticky = 1'b0; v.cnt = 8'd0;
      vecs[i] = v;
    end
    // No strobe: keep source 23's word.
    vecs[24] = '{strobes: 24'h000000, clr: 1'b0, bus: 32'h1717_1717, sel: 5'd23,
                 valid: 1'b0, cont: 1'b0, sticky: 1'b0, cnt: 8'd0};
    // Bits 7 and 12: lowest wins, contention.
    vecs[25] = '{strobes: 24'h001080, clr: 1'b0, bus: 32'h0707_0707, sel: 5'd7,
                 valid: 1'b1, cont: 1'b1, sticky: 1'b1, cnt: 8'd1};
    // err_clr alone with a single load.
    vecs[26] = '{strobes: 24'h000004, clr: 1'b1, bus: 32'h0202_0202, sel: 5'd2,
                 valid: 1'b1, cont: 1'b0, sticky: 1'b0, cnt: 8'd0};
    // Bits 22 and 23.
    vecs[27] = '{strobes: 24'hC00000, clr: 1'b0, bus: 32'h1616_1616, sel: 5'd22,
                 valid: 1'b1, cont: 1'b1, sticky: 1'b1, cnt: 8'd1};
    // err_clr with contention on bits 0 and 1: count loads 1, not 2.
    vecs[28] = '{strobes: 24'h000003, clr: 1'b1, bus: 32'h0000_0000, sel: 5'd0,
                 valid: 1'b1, cont: 1'b1, sticky: 1'b1, cnt: 8'd1};
    // err_clr with no strobe: status clears, bus held.
    vecs[29] = '{strobes: 24'h000000, clr: 1'b1, bus: 32'h0000_0000, sel: 5'd0,
                 valid: 1'b0, cont: 1'b0, sticky: 1'b0, cnt: 8'd0};

    // Reset state
    clear_n = 1'b0;
    src_out = '0;
    err_clr = 1'b0;
    src_data = '0;
    step();
    check_all("reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    clear_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NUM_SRC; i++) begin
      pattern = DATA_WIDTH'(i) * 32'h0101_0101;
      set_word(i, pattern);
    end
    foreach (vecs[i]) begin
      src_out = vecs[i].strobes;
      err_clr = vecs[i].clr;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].bus, vecs[i].sel, vecs[i].valid,
                vecs[i].cont, vecs[i].sticky, vecs[i].cnt);
    end
    err_clr = 1'b0;

    // Single driver: PC
    set_word(SRC_PC, 32'h0000_1234);
    src_out = '0;
    src_out[SRC_PC] = 1'b1;
    step();
    check_all("pc", 32'h0000_1234, 5'd20, 1'b1, 1'b0, 1'b0, 8'd0);

    // Keeper: R5 loads, then holds for 3 idle cycles while R5 changes
    set_word(SRC_R5, 32'hDEAD_BEEF);
    src_out = '0;
    src_out[SRC_R5] = 1'b1;
    step();
    check("keep_load.bus", bus_mux_out, 32'hDEAD_BEEF);
    src_out = '0;
    set_word(SRC_R5, 32'h1);
    for (int c = 0; c < 3; c++) begin
      step();
      check_all($sformatf("keep%0d", c), 32'hDEAD_BEEF, 5'd5, 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // Contention: R3 and MDR
    set_word(SRC_R3, 32'hA);
    set_word(SRC_MDR, 32'hB);
    src_out = '0;
    src_out[SRC_R3] = 1'b1;
    src_out[SRC_MDR] = 1'b1;
    step();
    check_all("cont", 32'hA, 5'd3, 1'b1, 1'b1, 1'b1, 8'd1);
    src_out = '0;
    step();
    check_all("cont_after", 32'hA, 5'd3, 1'b0, 1'b0, 1'b1, 8'd1);

    // Saturation: clear, then 300 contention cycles
    err_clr = 1'b1;
    step();
    check("sat_pre.cnt", 32'(contention_cnt), 32'd0);
    err_clr = 1'b0;
    src_out[SRC_R3] = 1'b1;
    src_out[SRC_MDR] = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (c == 254) check("sat254.cnt", 32'(contention_cnt), 32'd254);
      if (c == 255) check("sat255.cnt", 32'(contention_cnt), 32'd255);
    end
    check("sat300.cnt", 32'(contention_cnt), 32'd255);
    check("sat300.sticky", 32'(contention_sticky), 32'd1);
    src_out = '0;
    err_clr = 1'b1;
    step();
    check_all("clr_alone", 32'hA, 5'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    src_out[SRC_R3] = 1'b1;
    src_out[SRC_MDR] = 1'b1;
    step();
    check_all("clr_with_cont", 32'hA, 5'd3, 1'b1, 1'b1, 1'b1, 8'd1);
    err_clr = 1'b0;

    // Reset mid-operation: strobe in the reset cycle is discarded
    set_word(SRC_R1, 32'hFFFF_FFFF);
    src_out = '0;
    src_out[SRC_R1] = 1'b1;
    step();
    check("pre_rst.bus", bus_mux_out, 32'hFFFF_FFFF);
    set_word(SRC_R0, 32'h7);
    src_out = '0;
    src_out[SRC_R0] = 1'b1;
    src_out[SRC_R2] = 1'b1;
    err_clr = 1'b1;
    clear_n = 1'b0;
    step();
    check_all("mid_rst", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    clear_n = 1'b1;
    err_clr = 1'b0;
    src_out = '0;
    src_out[SRC_R0] = 1'b1;
    step();
    check_all("post_rst", 32'h7, 5'd0, 1'b1, 1'b0, 1'b0, 8'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_mux_driver.md
Name: bus_mux_driver

Overview:
- Drives the shared datapath bus. It collects the BusMuxIn outputs of all source registers and the one-hot source-enable strobes from control, then drives BusMuxOut back to every register input.
- It encodes the one-hot strobes to a source index and selects that source's data into a registered bus output.
- A keeper holds the last value when no source drives.
- It detects multi-driver contention and counts those events for debug.

Parameters:
- DATA_WIDTH, 32, width of each source word and of the bus.
- NUM_SRC, 24, number of bus sources. Index order: R0–R15, HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSIGN.
- SEL_WIDTH, 5, encoded select width; must satisfy 2**SEL_WIDTH >= NUM_SRC.
- ERR_CNT_WIDTH, 8, width of the contention event counter.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  synchronous active-low reset.
- src_data  in  NUM_SRC*DATA_WIDTH  concatenated source words; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_out  in  NUM_SRC  one-hot drive strobes from control; bit i requests that source i drive the bus.
- err_clr  in  1  clears the sticky contention status and the counter.
- BusMuxOut  out  DATA_WIDTH  registered bus value.
- bus_sel  out  SEL_WIDTH  registered encoded index of the source driving the current BusMuxOut.
- bus_valid  out  1  high when BusMuxOut was loaded from a source in the previous cycle.
- contention  out  1  single-cycle pulse, aligned with BusMuxOut, marking a cycle where more than one strobe was set.
- contention_sticky  out  1  latched contention flag.
- contention_cnt  out  ERR_CNT_WIDTH  saturating count of contention cycles.

Behaviour:
- Reset is synchronous and active-low: clear_n sampled low at a rising clock edge resets all state.
- Reset values: BusMuxOut=0, bus_sel=0, bus_valid=0, contention=0, contention_sticky=0, contention_cnt=0.
- Reset has priority over all other inputs in the same cycle, including err_clr and src_out.
- Latency: strobes and data sampled at edge N appear on BusMuxOut after edge N. Exactly one register stage; no combinational path from src_* to outputs.
- Encoding: the lowest set bit of src_out wins (priority encoder). bus_sel takes that index; BusMuxOut takes src_data of that index.
- src_out bits at or above NUM_SRC do not exist. The encoder never produces an index >= NUM_SRC.
- No strobe (src_out==0): keeper mode.
  - BusMuxOut and bus_sel hold their previous values.
  - bus_valid=0 for the next cycle.
- Exactly one strobe: normal load; bus_valid=1 and contention=0 for the next cycle.
- Two or more strobes:
  - Load from the lowest index as above; bus_valid=1.
  - contention=1 for that cycle only.
  - contention_sticky set to 1.
  - contention_cnt increments by 1, saturating at all-ones (never wraps).
- err_clr:
  - Asserted alone: clears contention_sticky and contention_cnt at the next edge.
  - Asserted in the same cycle as a new contention event: the counter loads 1, sticky=1, and contention pulses. The new event wins over the clear.
  - err_clr does not affect BusMuxOut, bus_sel or bus_valid.
- Reset mid-stream: a strobe present in the reset cycle is discarded. BusMuxOut=0 after that edge. The first post-reset strobe loads normally.
- All data is passed unmodified; no sign extension or truncation is applied.

Decomposition:
- Shared package (cpu_bus_pkg): DATA_WIDTH, NUM_SRC, SEL_WIDTH constants, plus named source-index constants (SRC_R0…SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_CSIGN).
- One combinational sub-module, bus_encoder.
  - Input: NUM_SRC one-hot strobes.
  - Outputs: SEL_WIDTH index, any_set, multi_set.
- The top level holds the output register, the keeper and the contention counter.

Test Plan:
- Single driver: src_out bit SRC_PC only, PC word=32'h0000_1234 → after one edge BusMuxOut=32'h0000_1234, bus_sel=20, bus_valid=1, contention=0.
- Keeper: load R5=32'hDEAD_BEEF, then src_out=0 for 3 cycles while changing R5 to 32'h1 → BusMuxOut stays 32'hDEAD_BEEF, bus_sel=5, bus_valid=0 for those 3 cycles.
- Contention: src_out sets R3 and MDR with R3=32'hA, MDR=32'hB → BusMuxOut=32'hA, bus_sel=3, contention one-cycle pulse, sticky=1, cnt=1.
- Saturation and clear: 300 consecutive contention cycles → cnt=255, sticky=1. Pulse err_clr alone → cnt=0, sticky=0. err_clr together with contention → cnt=1.
- Reset mid-operation: BusMuxOut=32'hFFFF_FFFF, then clear_n low for one edge with src_out bit R0 set and R0=32'h7 → all outputs reset (BusMuxOut=0). Next cycle, R0 strobe → BusMuxOut=32'h7 after one edge.
- Sweep: each source i in 0..23 carrying a data value equal to i*32'h0101_0101 → every index loads correctly with bus_sel=i and no contention.
